// File: rtl/mc_cpu_core_if.sv
// Memory bus between the multicycle core and its memory.
// One outstanding access at a time: the core holds mem_req and the address/data until mem_ack.
interface mc_cpu_core_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mc_cpu_core.sv
// Multicycle MIPS-subset core with a single shared instruction/data memory port.
// One FSM walks each instruction through fetch, decode, execute, memory and writeback.
module mc_cpu_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP  = 6'b111111,
  parameter bit          SHIFT_EN = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  mc_cpu_core_if.master bus,
  output logic          halted,
  output logic          illegal
);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;
  localparam logic [5:0] FnSll = 6'b000000;
  localparam logic [5:0] FnSrl = 6'b000010;

  typedef enum logic [3:0] {
    StFetch, StDecode, StExecR, StWbR, StExecI, StWbI, StMemAddr, StMemRd,
    StWbMem, StMemWr, StBranch, StJump, StJal, StHalt, StIllegal
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, ir_q, mdr_q, a_q, b_q, alu_out_q;
  logic [31:0] rf [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] imm_sext, rs_val, rt_val, alu_r;
  logic        r_ok;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign shamt    = ir_q[10:6];
  assign funct    = ir_q[5:0];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
  // r0 is hardwired to zero on read; its storage is never written.
  assign rs_val   = (rs == 5'd0) ? 32'd0 : rf[rs];
  assign rt_val   = (rt == 5'd0) ? 32'd0 : rf[rt];

  assign halted  = !rst && ((state_q == StHalt) || (state_q == StIllegal));
  assign illegal = !rst && (state_q == StIllegal);

  // R-type ALU result and funct legality.
  always_comb begin
    alu_r = 32'd0;
    r_ok  = 1'b0;
    case (funct)
      FnAdd: begin alu_r = a_q + b_q; r_ok = 1'b1; end
      FnSub: begin alu_r = a_q - b_q; r_ok = 1'b1; end
      FnAnd: begin alu_r = a_q & b_q; r_ok = 1'b1; end
      FnOr:  begin alu_r = a_q | b_q; r_ok = 1'b1; end
      FnSlt: begin alu_r = {31'd0, $signed(a_q) < $signed(b_q)}; r_ok = 1'b1; end
      FnSll: begin alu_r = b_q << shamt; r_ok = SHIFT_EN; end
      FnSrl: begin alu_r = b_q >> shamt; r_ok = SHIFT_EN; end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StFetch;
    else     state_q <= state_d;
  end

  // Next-state decode and memory bus outputs.
  always_comb begin
    state_d       = state_q;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = pc_q;
    bus.mem_wdata = b_q;
    unique case (state_q)
      StFetch: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ack) state_d = StDecode;
      end
      StDecode: begin
        if (opcode == HALT_OP) begin
          state_d = StHalt;
        end else begin
          case (opcode)
            OpRtype:    state_d = r_ok ? StExecR : StIllegal;
            OpLw, OpSw: state_d = StMemAddr;
            OpBeq:      state_d = StBranch;
            OpAddi:     state_d = StExecI;
            OpJ:        state_d = StJump;
            OpJal:      state_d = StJal;
            default:    state_d = StIllegal;
          endcase
        end
      end
      StExecR:   state_d = StWbR;
      StExecI:   state_d = StWbI;
      StMemAddr: state_d = (opcode == OpSw) ? StMemWr : StMemRd;
      StMemRd: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = alu_out_q;
        if (bus.mem_ack) state_d = StWbMem;
      end
      StMemWr: begin
        bus.mem_req  = 1'b1;
        bus.mem_we   = 1'b1;
        bus.mem_addr = alu_out_q;
        if (bus.mem_ack) state_d = StFetch;
      end
      StWbR, StWbI, StWbMem, StBranch, StJump, StJal: state_d = StFetch;
      StHalt, StIllegal: state_d = state_q;
      default: state_d = StFetch;
    endcase
    // Reset kills any request immediately so a late ack cannot complete it.
    if (rst) bus.mem_req = 1'b0;
  end

  // Datapath registers: PC, IR, MDR, A, B, ALUOut.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      ir_q      <= 32'd0;
      mdr_q     <= 32'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      alu_out_q <= 32'd0;
    end else begin
      case (state_q)
        StFetch: begin
          if (bus.mem_ack) begin
            ir_q <= bus.mem_rdata;
            pc_q <= pc_q + 32'd4;
          end
        end
        StDecode: begin
          a_q       <= rs_val;
          b_q       <= rt_val;
          alu_out_q <= pc_q + {imm_sext[29:0], 2'b00};
        end
        StExecR:            alu_out_q <= alu_r;
        StExecI, StMemAddr: alu_out_q <= a_q + imm_sext;
        StMemRd:            if (bus.mem_ack) mdr_q <= bus.mem_rdata;
        StBranch:           if (a_q == b_q) pc_q <= alu_out_q;
        StJump, StJal:      pc_q <= {pc_q[31:28], ir_q[25:0], 2'b00};
        default: ;
      endcase
    end
  end

  // Register file write port select.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = rt;
    rf_wdata = alu_out_q;
    case (state_q)
      StWbR:   begin rf_we = 1'b1; rf_waddr = rd; end
      StWbI:   rf_we = 1'b1;
      StWbMem: begin rf_we = 1'b1; rf_wdata = mdr_q; end
      // pc_q already holds the return address (PC+4) here.
      StJal:   begin rf_we = 1'b1; rf_waddr = 5'd31; rf_wdata = pc_q; end
      default: ;
    endcase
  end

  // Register file storage; r0 is never written.
  always_ff @(posedge clk) begin
    if (!rst && rf_we && (rf_waddr != 5'd0)) rf[rf_waddr] <= rf_wdata;
  end

endmodule
